// File: rtl/rob_phase_sequencer.sv
// Decodes ROB-commit phase markers from the DUT and variant cores, tracks a phase FSM per core,
// merges marker events into one back-pressured FIFO and owns finish_req.
// Optional watchdog: define ROB_SEQ_TIMEOUT_EN.
module rob_phase_sequencer #(
  parameter int LANES       = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int STAMP_W     = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LANES-1:0]        dut_valid,
  input  logic [32*LANES-1:0]     dut_inst,
  input  logic [LANES-1:0]        vnt_valid,
  input  logic [32*LANES-1:0]     vnt_inst,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [3:0]              evt_code,
  output logic                    evt_src,
  output logic [$clog2(LANES):0]  evt_lane,
  output logic [STAMP_W-1:0]      evt_stamp,
  output logic [2:0]              dut_phase,
  output logic [2:0]              vnt_phase,
  output logic                    phase_err,
  output logic                    overflow,
  output logic [15:0]             drop_cnt,
  output logic                    finish_req,
  output logic                    finish_done
);

  localparam int LANE_W = $clog2(LANES) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NCAND  = 2 * LANES + 1;

  typedef enum logic [2:0] {
    PH_VCTM  = 3'd0,
    PH_DELAY = 3'd1,
    PH_TEXE  = 3'd2,
    PH_LEAK  = 3'd3,
    PH_INIT  = 3'd4,
    PH_BIM   = 3'd5,
    PH_TRAIN = 3'd6,
    PH_IDLE  = 3'd7
  } phase_e;

  typedef struct packed {
    logic [3:0]         code;
    logic               src;
    logic [LANE_W-1:0]  lane;
    logic [STAMP_W-1:0] stamp;
  } evt_t;

  function automatic logic is_marker(input logic [31:0] inst);
    return (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013) && (inst[23:20] <= 4'd13);
  endfunction

  phase_e             dut_phase_q, dut_phase_d;
  phase_e             vnt_phase_q, vnt_phase_d;
  logic               phase_err_q, phase_err_d;
  logic               overflow_q, overflow_d;
  logic               finish_req_q, finish_req_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  evt_t               mem_q [FIFO_DEPTH];
  evt_t               mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [LANES-1:0]   dut_mk;
  logic [LANES-1:0]   vnt_mk;
  logic [3:0]         dut_code [LANES];
  logic [3:0]         vnt_code [LANES];
  logic               finish_hit;
  logic               wd_fire;
  logic               pop;
  logic               cand_vld [NCAND];
  evt_t               cand_evt [NCAND];
  logic [PTR_W-1:0]   wr_idx;
  int                 free_slots;
  int                 n_push;
  int                 n_drop;
  logic [16:0]        drop_sum;
  evt_t               head;

  // Once finish is requested the commit stream is frozen: no decode at all.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dut_code[i] = dut_inst[32*i+20 +: 4];
      vnt_code[i] = vnt_inst[32*i+20 +: 4];
      dut_mk[i]   = !finish_req_q && dut_valid[i] && is_marker(dut_inst[32*i +: 32]);
      vnt_mk[i]   = !finish_req_q && vnt_valid[i] && is_marker(vnt_inst[32*i +: 32]);
    end
  end

  always_comb begin
    dut_phase_d = dut_phase_q;
    vnt_phase_d = vnt_phase_q;
    phase_err_d = phase_err_q;
    finish_hit  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (dut_mk[i]) begin
        if (!dut_code[i][0]) begin
          dut_phase_d = phase_e'(dut_code[i][3:1]);
        end else if (dut_phase_d == phase_e'(dut_code[i][3:1])) begin
          dut_phase_d = PH_IDLE;
        end else begin
          phase_err_d = 1'b1;
        end
        if ((dut_code[i] == 4'd1) || (dut_code[i] == 4'd4)) begin
          finish_hit = 1'b1;
        end
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (vnt_mk[i]) begin
        if (!vnt_code[i][0]) begin
          vnt_phase_d = phase_e'(vnt_code[i][3:1]);
        end else if (vnt_phase_d == phase_e'(vnt_code[i][3:1])) begin
          vnt_phase_d = PH_IDLE;
        end else begin
          phase_err_d = 1'b1;
        end
      end
    end
  end

`ifdef ROB_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if ((dut_phase_q != PH_IDLE) && (dut_mk == '0)) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        wd_fire = !finish_req_q;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Candidate slot 0 is the watchdog event so it wins the last free slot.
  always_comb begin
    cand_vld[0]       = wd_fire;
    cand_evt[0].code  = 4'hF;
    cand_evt[0].src   = 1'b0;
    cand_evt[0].lane  = '0;
    cand_evt[0].stamp = stamp_q;
    for (int i = 0; i < LANES; i++) begin
      cand_vld[1+i]             = dut_mk[i];
      cand_evt[1+i].code        = dut_code[i];
      cand_evt[1+i].src         = 1'b0;
      cand_evt[1+i].lane        = LANE_W'(i);
      cand_evt[1+i].stamp       = stamp_q;
      cand_vld[1+LANES+i]       = vnt_mk[i];
      cand_evt[1+LANES+i].code  = vnt_code[i];
      cand_evt[1+LANES+i].src   = 1'b1;
      cand_evt[1+LANES+i].lane  = LANE_W'(i);
      cand_evt[1+LANES+i].stamp = stamp_q;
    end
  end

  always_comb begin
    pop        = (count_q != '0) && evt_ready;
    free_slots = FIFO_DEPTH - int'(count_q) + (pop ? 1 : 0);
    mem_d      = mem_q;
    wr_idx     = wr_ptr_q;
    n_push     = 0;
    n_drop     = 0;
    for (int c = 0; c < NCAND; c++) begin
      if (cand_vld[c]) begin
        if (n_push < free_slots) begin
          mem_d[wr_idx] = cand_evt[c];
          wr_idx        = wr_idx + PTR_W'(1);
          n_push        = n_push + 1;
        end else begin
          n_drop = n_drop + 1;
        end
      end
    end
    wr_ptr_d     = wr_idx;
    rd_ptr_d     = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
    count_d      = CNT_W'(int'(count_q) + n_push - (pop ? 1 : 0));
    drop_sum     = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d   = overflow_q || (n_drop != 0);
    finish_req_d = finish_req_q || finish_hit || wd_fire;
    stamp_d      = stamp_q + STAMP_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dut_phase_q  <= PH_IDLE;
      vnt_phase_q  <= PH_IDLE;
      phase_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      finish_req_q <= 1'b0;
      drop_cnt_q   <= '0;
      stamp_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      dut_phase_q  <= dut_phase_d;
      vnt_phase_q  <= vnt_phase_d;
      phase_err_q  <= phase_err_d;
      overflow_q   <= overflow_d;
      finish_req_q <= finish_req_d;
      drop_cnt_q   <= drop_cnt_d;
      stamp_q      <= stamp_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Event fields are forced to zero whenever nothing is queued.
  assign head        = mem_q[rd_ptr_q];
  assign evt_valid   = (count_q != '0);
  assign evt_code    = evt_valid ? head.code : 4'd0;
  assign evt_src     = evt_valid ? head.src : 1'b0;
  assign evt_lane    = evt_valid ? head.lane : '0;
  assign evt_stamp   = evt_valid ? head.stamp : '0;
  assign dut_phase   = dut_phase_q;
  assign vnt_phase   = vnt_phase_q;
  assign phase_err   = phase_err_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign finish_req  = finish_req_q;
  assign finish_done = finish_req_q && (count_q == '0);

endmodule
